// File: rtl/tpu_tile_sched_if.sv
// Handshake and buffer-side bundle for the TPU tile scheduler.
// Optional macro TILE_SCHED_PERF_EN adds the perf_cyc counter output.
interface tpu_tile_sched_if #(
    parameter int ARR   = 4,
    parameter int IDX_W = 8
);
    localparam int ROW_W = (ARR > 1) ? $clog2(ARR) : 1;

    logic             start;
    logic [3:0]       m;
    logic [3:0]       n;
    logic [3:0]       k;
    logic             done;
    logic             busy;
    logic             wr_en_a;
    logic             wr_en_b;
    logic             wr_en_c;
    logic [IDX_W-1:0] addr_a;
    logic [IDX_W-1:0] addr_b;
    logic [IDX_W-1:0] addr_c;
    logic             arr_clear;
    logic             arr_feed;
    logic [ROW_W-1:0] arr_row_sel;
`ifdef TILE_SCHED_PERF_EN
    logic [15:0]      perf_cyc;

    // Job requester side
    modport master (
        output start, m, n, k,
        input  done, busy, wr_en_a, wr_en_b, wr_en_c, addr_a, addr_b, addr_c,
               arr_clear, arr_feed, arr_row_sel, perf_cyc
    );

    // Scheduler side
    modport slave (
        input  start, m, n, k,
        output done, busy, wr_en_a, wr_en_b, wr_en_c, addr_a, addr_b, addr_c,
               arr_clear, arr_feed, arr_row_sel, perf_cyc
    );
`else
    // Job requester side
    modport master (
        output start, m, n, k,
        input  done, busy, wr_en_a, wr_en_b, wr_en_c, addr_a, addr_b, addr_c,
               arr_clear, arr_feed, arr_row_sel
    );

    // Scheduler side
    modport slave (
        input  start, m, n, k,
        output done, busy, wr_en_a, wr_en_b, wr_en_c, addr_a, addr_b, addr_c,
               arr_clear, arr_feed, arr_row_sel
    );
`endif
endinterface

// File: rtl/tpu_tile_sched.sv
// Tile scheduler for the TPU matmul datapath: walks C = A * B in ARR x ARR
// output tiles (nt outer, mt inner), issuing GBUFF_A/GBUFF_B read indices,
// systolic-array clear/feed/row-select strobes and GBUFF_OUT writes.
// Optional macro TILE_SCHED_PERF_EN adds perf_cyc (busy cycles of last job).
module tpu_tile_sched #(
    parameter int ARR     = 4,
    parameter int IDX_W   = 8,
    parameter int DRAIN_C = 7
) (
    input  logic           clk,
    input  logic           rst,
    tpu_tile_sched_if.slave bus
);
    localparam int ROW_W = (ARR > 1) ? $clog2(ARR) : 1;
    localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0] ARR_W   = IDX_W'(ARR);
    localparam logic [IDX_W-1:0] DRAIN_L = IDX_W'(DRAIN_C - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       m_q, n_q, k_q;
    logic [IDX_W-1:0] mt_q, nt_q, cnt_q;
    logic [IDX_W-1:0] addr_a_q, addr_b_q, addr_c_q;
    logic             feed_q;
    logic             accept, cnt_clr, tile_adv;
    logic [IDX_W-1:0] a_cur, b_cur, c_cur, rows_left, rows;
    logic             last_mt, last_nt;

    // Tile geometry: current indices, rows in this tile, last-tile flags
    always_comb begin
        a_cur     = mt_q * IDX_W'(k_q) + cnt_q;
        b_cur     = nt_q * IDX_W'(k_q) + cnt_q;
        c_cur     = nt_q * IDX_W'(m_q) + mt_q * ARR_W + cnt_q;
        rows_left = IDX_W'(m_q) - mt_q * ARR_W;
        rows      = (rows_left > ARR_W) ? ARR_W : rows_left;
        last_mt   = ((mt_q + ONE) * ARR_W) >= IDX_W'(m_q);
        last_nt   = ((nt_q + ONE) * ARR_W) >= IDX_W'(n_q);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic and per-phase control pulses
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        cnt_clr  = 1'b0;
        tile_adv = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = (bus.m != 4'd0 && bus.n != 4'd0 && bus.k != 4'd0)
                              ? S_CLR : S_DONE;
                end
            end
            S_CLR: begin
                cnt_clr = 1'b1;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (cnt_q == IDX_W'(k_q) - ONE) begin
                    cnt_clr = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_L) begin
                    cnt_clr = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt_q == rows - ONE) begin
                    cnt_clr  = 1'b1;
                    tile_adv = 1'b1;
                    state_d  = (last_mt && last_nt) ? S_DONE : S_CLR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Phase counter: kk in FEED, drain cycles in DRAIN, row r in WRITE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cnt_clr || accept) begin
            cnt_q <= '0;
        end else if (state_q == S_FEED || state_q == S_DRAIN || state_q == S_WRITE) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    // Job dimensions captured on accept; tile walk with mt as the inner loop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q  <= '0;
            n_q  <= '0;
            k_q  <= '0;
            mt_q <= '0;
            nt_q <= '0;
        end else if (accept) begin
            m_q  <= bus.m;
            n_q  <= bus.n;
            k_q  <= bus.k;
            mt_q <= '0;
            nt_q <= '0;
        end else if (tile_adv) begin
            if (last_mt) begin
                mt_q <= '0;
                nt_q <= nt_q + ONE;
            end else begin
                mt_q <= mt_q + ONE;
            end
        end
    end

    // Address hold registers so indices stay put outside their phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
        end else begin
            if (state_q == S_FEED) begin
                addr_a_q <= a_cur;
                addr_b_q <= b_cur;
            end
            if (state_q == S_WRITE) addr_c_q <= c_cur;
        end
    end

    // Buffer read data arrives one cycle after the index is issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) feed_q <= 1'b0;
        else      feed_q <= (state_q == S_FEED);
    end

`ifdef TILE_SCHED_PERF_EN
    logic [15:0] perf_q;

    // Busy-cycle counter for the last job, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if (state_q != S_IDLE && perf_q != 16'hFFFF) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign bus.perf_cyc = perf_q;
`endif

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.arr_clear   = (state_q == S_CLR);
    assign bus.wr_en_c     = (state_q == S_WRITE);
    assign bus.arr_feed    = feed_q;
    assign bus.wr_en_a     = 1'b0;
    assign bus.wr_en_b     = 1'b0;
    assign bus.addr_a      = (state_q == S_FEED)  ? a_cur : addr_a_q;
    assign bus.addr_b      = (state_q == S_FEED)  ? b_cur : addr_b_q;
    assign bus.addr_c      = (state_q == S_WRITE) ? c_cur : addr_c_q;
    assign bus.arr_row_sel = (state_q == S_WRITE) ? cnt_q[ROW_W-1:0] : '0;

endmodule

// File: tb/tb_tpu_tile_sched.sv
// Directed bench for tpu_tile_sched: table of whole-job vectors plus
// hand-written sequences for start re-pulse and mid-WRITE reset.
module tb_tpu_tile_sched;
    logic clk = 1'b0;
    logic rst;

    tpu_tile_sched_if #(.ARR(4), .IDX_W(8)) sif ();

    tpu_tile_sched #(.ARR(4), .IDX_W(8), .DRAIN_C(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int m, n, k;
        int done_cyc, wr, clr, feed;
        int csum, asum, bsum, selsum, first_wr;
    } vec_t;

    vec_t vecs[8];

    int n_cmp = 0;
    int n_err = 0;

    int st_done, st_wr, st_clr, st_feed, st_csum, st_asum, st_bsum;
    int st_selsum, st_first_wr, st_busy, st_rdwr, st_post, st_timeout;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one job and collect per-job statistics sampled on negedges.
    // Cycle c is the cycle after the c-th rising edge following acceptance.
    task automatic run_job(input int mm, input int nn, input int kk, input int repulse);
        int  prev_a, prev_b;
        bit  fin;
        st_done = 0; st_wr = 0; st_clr = 0; st_feed = 0; st_csum = 0;
        st_asum = 0; st_bsum = 0; st_selsum = 0; st_first_wr = 0;
        st_busy = 0; st_rdwr = 0; st_post = 0; st_timeout = 0;
        prev_a = 0; prev_b = 0; fin = 1'b0;
        @(negedge clk);
        sif.start = 1'b1;
        sif.m = 4'(mm); sif.n = 4'(nn); sif.k = 4'(kk);
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        sif.m = 4'hF; sif.n = 4'hF; sif.k = 4'hF;
        for (int c = 1; c <= 2000 && !fin; c++) begin
            @(negedge clk);
            if (sif.busy)      st_busy++;
            if (sif.arr_clear) st_clr++;
            if (sif.arr_feed) begin
                st_feed++;
                st_asum += prev_a;
                st_bsum += prev_b;
            end
            if (sif.wr_en_c) begin
                st_wr++;
                st_csum   += int'(sif.addr_c);
                st_selsum += int'(sif.arr_row_sel);
                if (st_first_wr == 0) st_first_wr = c;
            end
            if (sif.wr_en_a || sif.wr_en_b) st_rdwr++;
            prev_a = int'(sif.addr_a);
            prev_b = int'(sif.addr_b);
            if (sif.done) begin
                st_done = c;
                fin = 1'b1;
            end
            sif.start = (c == repulse) ? 1'b1 : 1'b0;
        end
        sif.start = 1'b0;
        st_timeout = fin ? 0 : 1;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            if (sif.done || sif.busy || sif.wr_en_c || sif.arr_clear || sif.arr_feed)
                st_post++;
        end
    endtask

    task automatic check_job(input string tag, input vec_t v);
        chk({tag, " timeout"},  st_timeout,  0);
        chk({tag, " done_cyc"}, st_done,     v.done_cyc);
        chk({tag, " busy_cyc"}, st_busy,     v.done_cyc);
        chk({tag, " writes"},   st_wr,       v.wr);
        chk({tag, " clears"},   st_clr,      v.clr);
        chk({tag, " feeds"},    st_feed,     v.feed);
        chk({tag, " csum"},     st_csum,     v.csum);
        chk({tag, " asum"},     st_asum,     v.asum);
        chk({tag, " bsum"},     st_bsum,     v.bsum);
        chk({tag, " selsum"},   st_selsum,   v.selsum);
        chk({tag, " first_wr"}, st_first_wr, v.first_wr);
        chk({tag, " wr_ab"},    st_rdwr,     0);
        chk({tag, " post_idle"}, st_post,    0);
`ifdef TILE_SCHED_PERF_EN
        chk({tag, " perf_cyc"}, int'(sif.perf_cyc), v.done_cyc);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          m  n  k  done  wr clr feed  csum  asum  bsum sel fwr
        vecs[0] = '{4, 4, 4,  17,  4,  1,   4,    6,    6,    6,  6, 13};
        vecs[1] = '{5, 4, 2,  26,  5,  2,   4,   10,    6,    2,  6, 11};
        vecs[2] = '{4, 8, 3,  31,  8,  2,   6,   28,    6,   15, 12, 12};
        vecs[3] = '{4, 4, 0,   1,  0,  0,   0,    0,    0,    0,  0,  0};
        vecs[4] = '{9, 5, 1,  73, 18,  6,   6,  153,    6,    3, 24, 10};
        vecs[5] = '{1, 1, 1,  11,  1,  1,   1,    0,    0,    0,  0, 10};
        vecs[6] = '{15,15,15, 429, 60, 16, 240, 1770, 7080, 7080, 84, 24};
        vecs[7] = '{0, 3, 3,   1,  0,  0,   0,    0,    0,    0,  0,  0};

        rst = 1'b0;
        sif.start = 1'b0;
        sif.m = '0; sif.n = '0; sif.k = '0;
        repeat (3) @(negedge clk);
        chk("reset busy",      int'(sif.busy),      0);
        chk("reset done",      int'(sif.done),      0);
        chk("reset wr_en_c",   int'(sif.wr_en_c),   0);
        chk("reset arr_clear", int'(sif.arr_clear), 0);
        chk("reset arr_feed",  int'(sif.arr_feed),  0);
        chk("reset addr_a",    int'(sif.addr_a),    0);
        chk("reset addr_b",    int'(sif.addr_b),    0);
        chk("reset addr_c",    int'(sif.addr_c),    0);
`ifdef TILE_SCHED_PERF_EN
        chk("reset perf_cyc",  int'(sif.perf_cyc),  0);
`endif
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].m, vecs[i].n, vecs[i].k, 0);
            check_job($sformatf("vec%0d", i), vecs[i]);
        end

        // start re-pulsed (with different dims) during FEED is ignored
        run_job(4, 4, 4, 3);
        check_job("repulse", vecs[0]);

        // reset asserted mid-WRITE drops strobes immediately
        @(negedge clk);
        sif.start = 1'b1;
        sif.m = 4'd4; sif.n = 4'd4; sif.k = 4'd4;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        repeat (14) @(negedge clk);
        chk("midwr wr_en_c before", int'(sif.wr_en_c), 1);
        chk("midwr addr_c before",  int'(sif.addr_c),  1);
        #2;
        rst = 1'b0;
        #1;
        chk("midwr wr_en_c after",  int'(sif.wr_en_c),     0);
        chk("midwr busy after",     int'(sif.busy),        0);
        chk("midwr addr_c after",   int'(sif.addr_c),      0);
        chk("midwr row_sel after",  int'(sif.arr_row_sel), 0);
        chk("midwr done after",     int'(sif.done),        0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_job(4, 4, 4, 0);
        check_job("post_rst", vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
